// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives rPLL reset, qualifies LOCK and generates the PLL-domain system reset.
// Runs on the 27 MHz crystal clock, so it keeps working while the PLL is unlocked.
// Ports:
//   clk             27 MHz crystal clock
//   reset           asynchronous active-high reset
//   lock_in         rPLL LOCK, asynchronous to clk
//   pll_reset       rPLL RESET, high holds the PLL in reset
//   sys_reset       active-high reset for PLL-domain logic (consumer resynchronizes deassertion)
//   ready           high only while running with a qualified lock
//   lock_loss_count saturating count of lock losses while running
//   retry_count     saturating count of timeout-driven PLL resets
// Optional: define PLL_LOCK_EVENT_COUNT_EN to implement the two event counters;
// otherwise they read 0 and no counter flops exist.
module pll_lock_supervisor #(
    parameter int PLL_RESET_CYCLES = 16,
    parameter int STABLE_CYCLES    = 27000,
    parameter int LOCK_TIMEOUT     = 270000,
    parameter int COUNT_WIDTH      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock_in,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic [7:0] retry_count
);
    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
    localparam logic [COUNT_WIDTH-1:0] RST_LAST = COUNT_WIDTH'(PLL_RESET_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] STB_LAST = COUNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TO_LAST  = COUNT_WIDTH'(LOCK_TIMEOUT - 1);
    logic                   lock_m, lock_s;
    state_t                 state, state_n;
    logic [COUNT_WIDTH-1:0] cnt, cnt_n;
    always_ff @(posedge clk or posedge reset)
        if (reset) {lock_m, lock_s} <= 2'b00;
        else       {lock_m, lock_s} <= {lock_in, lock_m};
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            PLL_RST:
                if (cnt == RST_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT_LOCK;
                end
            WAIT_LOCK:
                // lock wins over a coincident timeout
                if (lock_s || cnt == TO_LAST) begin
                    cnt_n   = '0;
                    state_n = lock_s ? STABLE : PLL_RST;
                end
            STABLE:
                // any sampled drop restarts qualification from zero
                if (!lock_s || cnt == STB_LAST) begin
                    cnt_n   = '0;
                    state_n = lock_s ? RUN : WAIT_LOCK;
                end
            RUN: begin
                cnt_n   = '0;
                state_n = lock_s ? RUN : WAIT_LOCK;
            end
            default: begin
                cnt_n   = '0;
                state_n = PLL_RST;
            end
        endcase
    end
    // outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pll_reset <= state_n == PLL_RST;
            sys_reset <= state_n != RUN;
            ready     <= state_n == RUN;
        end
`ifdef PLL_LOCK_EVENT_COUNT_EN
    logic retry_ev, loss_ev;
    assign retry_ev = state == WAIT_LOCK && !lock_s && cnt == TO_LAST;
    assign loss_ev  = state == RUN && !lock_s;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else begin
            if (retry_ev && retry_count != 8'hff) retry_count <= retry_count + 1'b1;
            if (loss_ev && lock_loss_count != 8'hff) lock_loss_count <= lock_loss_count + 1'b1;
        end
`else
    assign retry_count     = 8'd0;
    assign lock_loss_count = 8'd0;
`endif
endmodule
